// File: rtl/hazard_pkg.sv
// Shared constants for the forwarding/hazard controller: operand select
// encodings and the width of the mul/div countdown counter.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;

    // Counter must hold MD_LAT itself, hence lat+1 states.
    function automatic int md_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single in-flight mul/div operation: countdown to writeback,
// occupancy and the pending destination register.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LAT     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  md_start_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [REG_ADDR_W-1:0] md_wr_rd,
    output logic                  pend_v,
    output logic [REG_ADDR_W-1:0] pend_rd
);

    localparam int CNT_W = md_cnt_w(MD_LAT);

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_pend_v;
    logic [REG_ADDR_W-1:0] r_pend_rd;
    logic                  w_done;
    logic                  w_accept;

    assign w_done   = r_busy && (r_cnt == CNT_W'(1));
    // A start in the done cycle is accepted so issue can be back-to-back.
    assign w_accept = md_start_e && (!r_busy || w_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_pend_v  <= 1'b0;
            r_pend_rd <= '0;
        end else if (w_accept) begin
            r_cnt     <= CNT_W'(MD_LAT);
            r_busy    <= 1'b1;
            r_pend_v  <= (rd_e != '0);
            r_pend_rd <= rd_e;
        end else if (w_done) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_pend_v <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign md_busy  = r_busy;
    assign md_done  = w_done;
    assign md_wr_rd = r_pend_rd;
    assign pend_v   = r_pend_v;
    assign pend_rd  = r_pend_rd;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// E-stage operand forwarding plus load-use, mul/div RAW and mul/div
// structural hazard detection for the 5-stage pipeline.
module fwd_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_RD     = 2,
    parameter int MD_LAT     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rs_d,
    input  logic [NUM_RD-1:0]            rs_valid_d,
    input  logic                         md_start_d,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rs_e,
    input  logic [NUM_RD*DATA_W-1:0]     rf_data_e,
    input  logic [REG_ADDR_W-1:0]        rd_e,
    input  logic                         regwrite_e,
    input  logic                         memtoreg_e,
    input  logic                         md_start_e,
    input  logic [DATA_W-1:0]            alu_out_m,
    input  logic [REG_ADDR_W-1:0]        rd_m,
    input  logic                         regwrite_m,
    input  logic [DATA_W-1:0]            result_w,
    input  logic [REG_ADDR_W-1:0]        rd_w,
    input  logic                         regwrite_w,
    output logic [NUM_RD*DATA_W-1:0]     operand_e,
    output logic [NUM_RD*2-1:0]          fwd_sel_e,
    output logic                         stall_f,
    output logic                         stall_d,
    output logic                         flush_e,
    output logic                         md_busy,
    output logic                         md_done,
    output logic [REG_ADDR_W-1:0]        md_wr_rd
);

    logic                  w_pend_v;
    logic [REG_ADDR_W-1:0] w_pend_rd;
    logic [NUM_RD-1:0]     w_lu_hit;
    logic [NUM_RD-1:0]     w_raw_hit;
    logic                  w_lu_hazard;
    logic                  w_raw_hazard;
    logic                  w_struct_hazard;
    logic                  w_stall;

    md_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MD_LAT     (MD_LAT)
    ) u_md_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_start_e (md_start_e),
        .rd_e       (rd_e),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_wr_rd   (md_wr_rd),
        .pend_v     (w_pend_v),
        .pend_rd    (w_pend_rd)
    );

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_opnd
            logic [REG_ADDR_W-1:0] w_rs_e;
            logic [REG_ADDR_W-1:0] w_rs_d;
            logic [1:0]            w_sel;
            logic [DATA_W-1:0]     w_opnd;

            assign w_rs_e = rs_e[gi*REG_ADDR_W +: REG_ADDR_W];
            assign w_rs_d = rs_d[gi*REG_ADDR_W +: REG_ADDR_W];

            // M is checked before W so the youngest producer wins.
            always_comb begin
                w_sel  = FWD_RF;
                w_opnd = rf_data_e[gi*DATA_W +: DATA_W];
                if (w_rs_e != '0) begin
                    if (regwrite_m && (rd_m == w_rs_e)) begin
                        w_sel  = FWD_M;
                        w_opnd = alu_out_m;
                    end else if (regwrite_w && (rd_w == w_rs_e)) begin
                        w_sel  = FWD_W;
                        w_opnd = result_w;
                    end
                end
            end

            assign fwd_sel_e[gi*2 +: 2]          = w_sel;
            assign operand_e[gi*DATA_W +: DATA_W] = w_opnd;

            assign w_lu_hit[gi]  = rs_valid_d[gi] && memtoreg_e && regwrite_e &&
                                   (rd_e != '0) && (rd_e == w_rs_d);
            assign w_raw_hit[gi] = rs_valid_d[gi] && (w_rs_d != '0) &&
                                   ((w_pend_v && (w_pend_rd == w_rs_d) && !md_done) ||
                                    (md_start_e && (rd_e == w_rs_d)));
        end
    endgenerate

    assign w_lu_hazard     = |w_lu_hit;
    assign w_raw_hazard    = |w_raw_hit;
    assign w_struct_hazard = md_start_d && md_busy && !md_done;
    assign w_stall         = w_lu_hazard || w_raw_hazard || w_struct_hazard;

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_e = w_stall;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and randomized checks of fwd_hazard_ctrl against a cycle-indexed
// reference model of forwarding, hazards and the mul/div issue window.
module tb_fwd_hazard_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 2;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  rs_d;
    logic [NR-1:0]     rs_valid_d;
    logic              md_start_d;
    logic [NR*AW-1:0]  rs_e;
    logic [NR*DW-1:0]  rf_data_e;
    logic [AW-1:0]     rd_e;
    logic              regwrite_e;
    logic              memtoreg_e;
    logic              md_start_e;
    logic [DW-1:0]     alu_out_m;
    logic [AW-1:0]     rd_m;
    logic              regwrite_m;
    logic [DW-1:0]     result_w;
    logic [AW-1:0]     rd_w;
    logic              regwrite_w;
    logic [NR*DW-1:0]  operand_e;
    logic [NR*2-1:0]   fwd_sel_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_e;
    logic              md_busy;
    logic              md_done;
    logic [AW-1:0]     md_wr_rd;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the mul/div op issued at cycle md_t occupies cycles md_t+1..md_t+LAT.
    int       cyc  = 0;
    int       md_t = -1000;
    logic [AW-1:0] m_rd = '0;

    fwd_hazard_ctrl #(
        .DATA_W(DW), .REG_ADDR_W(AW), .NUM_RD(NR), .MD_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rs_valid_d(rs_valid_d),
        .md_start_d(md_start_d), .rs_e(rs_e), .rf_data_e(rf_data_e),
        .rd_e(rd_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .md_start_e(md_start_e), .alu_out_m(alu_out_m), .rd_m(rd_m),
        .regwrite_m(regwrite_m), .result_w(result_w), .rd_w(rd_w),
        .regwrite_w(regwrite_w), .operand_e(operand_e), .fwd_sel_e(fwd_sel_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .md_busy(md_busy), .md_done(md_done), .md_wr_rd(md_wr_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_busy();
        return (cyc > md_t) && (cyc <= md_t + LAT);
    endfunction

    function automatic bit m_done();
        return cyc == md_t + LAT;
    endfunction

    function automatic logic [AW-1:0] rs_of(input logic [NR*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    task automatic model_reset();
        md_t = -1000;
        m_rd = '0;
    endtask

    // Clock edge: advance the model with the inputs that were present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (md_start_e && (!m_busy() || m_done())) begin
                md_t = cyc;
                m_rd = rd_e;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic check_model();
        logic [1:0]    es;
        logic [DW-1:0] ev;
        logic [AW-1:0] r;
        bit lu, raw, st, pv;
        #1;
        for (int i = 0; i < NR; i++) begin
            r  = rs_of(rs_e, i);
            es = 2'd0;
            ev = rf_data_e[i*DW +: DW];
            if (r != 0 && regwrite_m && rd_m == r) begin
                es = 2'd2; ev = alu_out_m;
            end else if (r != 0 && regwrite_w && rd_w == r) begin
                es = 2'd1; ev = result_w;
            end
            chk($sformatf("sel%0d", i), 64'(fwd_sel_e[i*2 +: 2]), 64'(es));
            chk($sformatf("opnd%0d", i), 64'(operand_e[i*DW +: DW]), 64'(ev));
        end
        lu = 0; raw = 0;
        pv = m_busy() && (m_rd != 0);
        for (int i = 0; i < NR; i++) begin
            r = rs_of(rs_d, i);
            if (rs_valid_d[i]) begin
                if (memtoreg_e && regwrite_e && rd_e != 0 && rd_e == r) lu = 1;
                if (r != 0 && ((pv && m_rd == r && !m_done()) || (md_start_e && rd_e == r))) raw = 1;
            end
        end
        st = md_start_d && m_busy() && !m_done();
        chk("stall_f", 64'(stall_f), 64'(lu || raw || st));
        chk("stall_d", 64'(stall_d), 64'(lu || raw || st));
        chk("flush_e", 64'(flush_e), 64'(lu || raw || st));
        chk("md_busy", 64'(md_busy), 64'(m_busy()));
        chk("md_done", 64'(md_done), 64'(m_done()));
        if (m_busy()) chk("md_wr_rd", 64'(md_wr_rd), 64'(m_rd));
    endtask

    task automatic idle_inputs();
        rs_d = '0; rs_valid_d = '0; md_start_d = 0; rs_e = '0; rf_data_e = '0;
        rd_e = '0; regwrite_e = 0; memtoreg_e = 0; md_start_e = 0;
        alu_out_m = '0; rd_m = '0; regwrite_m = 0; result_w = '0; rd_w = '0; regwrite_w = 0;
    endtask

    task automatic rand_inputs();
        rs_d       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
        rs_valid_d = NR'($urandom);
        md_start_d = 1'($urandom);
        rs_e       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
        rf_data_e  = {$urandom, $urandom};
        rd_e       = AW'($urandom_range(0, 7));
        regwrite_e = 1'($urandom);
        memtoreg_e = 1'($urandom);
        md_start_e = ($urandom_range(0, 3) == 0);
        alu_out_m  = $urandom;
        rd_m       = AW'($urandom_range(0, 7));
        regwrite_m = 1'($urandom);
        result_w   = $urandom;
        rd_w       = AW'($urandom_range(0, 7));
        regwrite_w = 1'($urandom);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(md_busy), 64'(0));
        chk("rst_done", 64'(md_done), 64'(0));
        chk("rst_wr_rd", 64'(md_wr_rd), 64'(0));
        chk("rst_stall", 64'(stall_f), 64'(0));
        rst_n = 1;

        // Forwarding: M beats W, then W alone, then register zero.
        tick();
        rs_e = {AW'(0), AW'(5)}; rf_data_e = {32'h0000_BEEF, 32'h5555_5555};
        regwrite_m = 1; rd_m = 5; alu_out_m = 32'hAAAA_0000;
        regwrite_w = 1; rd_w = 5; result_w = 32'h0000_1234;
        check_model();
        chk("fwd_m_sel", 64'(fwd_sel_e[1:0]), 64'(2));
        chk("fwd_m_val", 64'(operand_e[31:0]), 64'h0000_0000_AAAA_0000);
        regwrite_m = 0;
        check_model();
        chk("fwd_w_sel", 64'(fwd_sel_e[1:0]), 64'(1));
        chk("fwd_w_val", 64'(operand_e[31:0]), 64'h0000_1234);
        regwrite_m = 1; rd_m = 0;
        check_model();
        chk("r0_sel", 64'(fwd_sel_e[3:2]), 64'(0));
        chk("r0_val", 64'(operand_e[63:32]), 64'h0000_BEEF);

        // Load-use on operand 1, then the same with the operand not read.
        idle_inputs();
        memtoreg_e = 1; regwrite_e = 1; rd_e = 8; rs_d = {AW'(8), AW'(3)}; rs_valid_d = 2'b10;
        check_model();
        chk("lu_stall", 64'({stall_f, stall_d, flush_e}), 64'(3'b111));
        rs_valid_d = 2'b00;
        check_model();
        chk("lu_nostall", 64'({stall_f, stall_d, flush_e}), 64'(3'b000));

        // MD timing with a dependent consumer on r9.
        idle_inputs();
        tick();
        md_start_e = 1; rd_e = 9; rs_d = {AW'(0), AW'(9)}; rs_valid_d = 2'b01;
        check_model();
        chk("md_c0_stall", 64'(stall_d), 64'(1));
        for (int k = 1; k <= 5; k++) begin
            tick();
            md_start_e = 0; rd_e = 0;
            check_model();
            chk($sformatf("md_c%0d_busy", k), 64'(md_busy), 64'(k <= 4));
            chk($sformatf("md_c%0d_done", k), 64'(md_done), 64'(k == 4));
            chk($sformatf("md_c%0d_stall", k), 64'(stall_d), 64'(k <= 3));
            if (k <= 4) chk($sformatf("md_c%0d_rd", k), 64'(md_wr_rd), 64'(9));
        end

        // Issue interlock and back-to-back issue in the done cycle.
        idle_inputs();
        tick();
        md_start_e = 1; rd_e = 10;
        check_model();
        for (int k = 1; k <= 9; k++) begin
            tick();
            md_start_e = (k == 4); rd_e = (k == 4) ? AW'(11) : AW'(0);
            md_start_d = (k >= 2 && k <= 4);
            check_model();
            if (k >= 2 && k <= 4) chk($sformatf("st_c%0d", k), 64'(stall_f), 64'(k < 4));
            chk($sformatf("b2b_c%0d_busy", k), 64'(md_busy), 64'(k <= 8));
            chk($sformatf("b2b_c%0d_done", k), 64'(md_done), 64'(k == 4 || k == 8));
        end

        // Reset in cycle 2 of an MD op abandons it at once.
        idle_inputs();
        tick();
        md_start_e = 1; rd_e = 9;
        check_model();
        tick(); md_start_e = 0; rd_e = 0; check_model();
        tick(); check_model();
        rst_n = 0;
        model_reset();
        #1;
        chk("rstmid_busy", 64'(md_busy), 64'(0));
        chk("rstmid_done", 64'(md_done), 64'(0));
        tick();
        rst_n = 1; rs_d = {AW'(0), AW'(9)}; rs_valid_d = 2'b01;
        check_model();
        chk("rstmid_nostall", 64'(stall_d), 64'(0));

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            tick();
            rst_n = 1;
            rand_inputs();
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 0;
                model_reset();
            end
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
